// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter slice.
//   owner_e                 : which requester a transaction belongs to
//   SIZE_*                  : m_size / data_size encodings
//   DEFAULT_MAX_OUTSTANDING : default depth of the owner FIFO
package mem_arb_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like shared master bus between the arbiter and the downstream slave.
//   m_req/m_wr/m_size/m_addr/m_wstrb/m_wdata : request, driven by master
//   m_addr_ok                                : slave accepted the request
//   m_data_ok/m_rdata                        : in-order response from slave
interface mem_req_arbiter_if;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit transaction owners.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write din_i (ignored when full)
//   din_i      : owner bit to store
//   pop_i      : drop head entry (ignored when empty)
//   head_o     : owner of the oldest entry
//   empty_o    : no entries
//   full_o     : DEPTH entries held
//   count_o    : number of entries held
module owner_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointer overflow wraps modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the fetch (inst) and execute (data) requesters onto one
// SRAM-like master port and routes in-order responses back.
//   clk, reset          : clock, asynchronous active-high reset
//   inst_*              : fetch read channel
//   data_*              : load/store channel
//   m                   : shared master bus (mem_req_arbiter_if.master)
//   outstanding         : accepted-but-unanswered transaction count
//   err_spurious        : sticky, response seen with nothing outstanding
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_req,
  input  logic [31:0]              inst_addr,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [31:0]              inst_rdata,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [1:0]               data_size,
  input  logic [31:0]              data_addr,
  input  logic [3:0]               data_wstrb,
  input  logic [31:0]              data_wdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [31:0]              data_rdata,
  mem_req_arbiter_if.master        m,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_spurious
);
  logic   lock_valid_q, lock_valid_d;
  owner_e lock_owner_q, lock_owner_d;
  logic   err_q, err_d;
  owner_e owner;
  logic   owner_req;
  logic   fire;
  logic   full, empty, head, pop;

  always_comb begin
    if (lock_valid_q)  owner = lock_owner_q;
    else if (data_req) owner = OWNER_DATA;
    else               owner = OWNER_INST;
  end

  assign owner_req = (owner == OWNER_DATA) ? data_req : inst_req;

  // Reset gates the request combinationally so the bus is quiet the
  // moment reset rises, not only after the registers clear.
  assign m.m_req = ~reset & ~full & owner_req;
  assign fire    = m.m_req & m.m_addr_ok;

  always_comb begin
    m.m_wr    = 1'b0;
    m.m_size  = SIZE_WORD;
    m.m_addr  = inst_addr;
    m.m_wstrb = '0;
    m.m_wdata = '0;
    if (owner == OWNER_DATA) begin
      m.m_wr    = data_wr;
      m.m_size  = data_size;
      m.m_addr  = data_addr;
      m.m_wstrb = data_wstrb;
      m.m_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = fire & (owner == OWNER_INST);
  assign data_addr_ok = fire & (owner == OWNER_DATA);

  // A stalled request holds its grant; a withdrawn request frees it.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (fire) begin
      lock_valid_d = 1'b0;
    end else if (m.m_req & ~m.m_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_owner_d = owner;
    end else if (lock_valid_q & ~owner_req) begin
      lock_valid_d = 1'b0;
    end
  end

  assign pop   = m.m_data_ok & ~empty;
  assign err_d = err_q | (m.m_data_ok & empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_INST;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fire),
    .din_i   (owner == OWNER_DATA),
    .pop_i   (m.m_data_ok),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .count_o (outstanding)
  );

  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = m.m_rdata;
  assign data_rdata   = m.m_rdata;
  assign err_spurious = err_q;
endmodule
